// File: rtl/camera_seq_fsm.sv
// Capture sequencer for a 2x2 pixel array: erase in idle, integrate for the
// latched exposure time, then read row 1 and row 2 through the ADC.
module camera_seq_fsm #(
    parameter int EXP_WIDTH = 5,
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int ADC_HOLD  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Init,
    input  logic [EXP_WIDTH-1:0] Exp_time,
    output logic                 Erase,
    output logic                 Expose,
    output logic                 NRE_1,
    output logic                 NRE_2,
    output logic                 ADC,
    output logic                 Busy,
    output logic                 Done
);

    // state     | meaning
    // S_IDLE    | pixels held in erase, waiting for Init
    // S_EXPOSE  | integrating; exp_cnt counts the latched time down to 1
    // S_READOUT | rd_cnt walks row 1 then row 2 slots; last slot pulses Done

    localparam int P      = ADC_HOLD + 3;
    localparam int RD_LEN = 2 * P;
    localparam int RD_W   = $clog2(RD_LEN);

    localparam logic [EXP_WIDTH-1:0] T_MIN   = EXP_WIDTH'(EXP_MIN);
    localparam logic [EXP_WIDTH-1:0] T_MAX   = EXP_WIDTH'(EXP_MAX);
    localparam logic [EXP_WIDTH-1:0] E_ONE   = EXP_WIDTH'(1);
    localparam logic [RD_W-1:0]      R_ONE   = RD_W'(1);
    localparam logic [RD_W-1:0]      R_P     = RD_W'(P);
    localparam logic [RD_W-1:0]      R_LAST  = RD_W'(RD_LEN - 1);
    localparam logic [RD_W-1:0]      ADC_END = RD_W'(ADC_HOLD);
    localparam logic [RD_W-1:0]      NRE_END = RD_W'(ADC_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXPOSE  = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [EXP_WIDTH-1:0]  exp_cnt_q, exp_cnt_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic                  erase_q, erase_d;
    logic                  expose_q, expose_d;
    logic                  nre_1_q, nre_1_d;
    logic                  nre_2_q, nre_2_d;
    logic                  adc_q, adc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [EXP_WIDTH-1:0]  t_clamp;
    logic                  in_read;
    logic                  row2;
    logic [RD_W-1:0]       slot;
    logic                  nre_low;

    always_comb begin
        if (Exp_time < T_MIN) begin
            t_clamp = T_MIN;
        end else if (Exp_time > T_MAX) begin
            t_clamp = T_MAX;
        end else begin
            t_clamp = Exp_time;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        case (state_q)
            S_IDLE: begin
                rd_cnt_d = '0;
                if (Init) begin
                    state_d   = S_EXPOSE;
                    exp_cnt_d = t_clamp;
                end
            end
            S_EXPOSE: begin
                if (exp_cnt_q <= E_ONE) begin
                    state_d   = S_READOUT;
                    exp_cnt_d = '0;
                    rd_cnt_d  = '0;
                end else begin
                    exp_cnt_d = exp_cnt_q - E_ONE;
                end
            end
            S_READOUT: begin
                if (rd_cnt_q == R_LAST) begin
                    state_d  = S_IDLE;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + R_ONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                exp_cnt_d = '0;
                rd_cnt_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values line
    // up with the cycle the state register enters.
    always_comb begin
        in_read  = (state_d == S_READOUT);
        row2     = (rd_cnt_d >= R_P);
        slot     = row2 ? (rd_cnt_d - R_P) : rd_cnt_d;
        nre_low  = in_read && (slot <= NRE_END);
        erase_d  = (state_d == S_IDLE);
        expose_d = (state_d == S_EXPOSE);
        busy_d   = (state_d != S_IDLE);
        nre_1_d  = !(nre_low && !row2);
        nre_2_d  = !(nre_low && row2);
        adc_d    = in_read && (slot != '0) && (slot <= ADC_END);
        done_d   = in_read && (rd_cnt_d == R_LAST);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            exp_cnt_q <= '0;
            rd_cnt_q  <= '0;
            erase_q   <= 1'b1;
            expose_q  <= 1'b0;
            nre_1_q   <= 1'b1;
            nre_2_q   <= 1'b1;
            adc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_cnt_q <= exp_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            nre_1_q   <= nre_1_d;
            nre_2_q   <= nre_2_d;
            adc_q     <= adc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Erase  = erase_q;
    assign Expose = expose_q;
    assign NRE_1  = nre_1_q;
    assign NRE_2  = nre_2_q;
    assign ADC    = adc_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_camera_seq_fsm.sv
// Bench for camera_seq_fsm: default build and an ADC_HOLD=3 build share
// stimulus; both are checked every cycle against a timeline model.
module tb_camera_seq_fsm;

    logic       Clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic [4:0] exp_time = '0;

    logic erase0, expose0, nre1_0, nre2_0, adc0, busy0, done0;
    logic erase1, expose1, nre1_1, nre2_1, adc1, busy1, done1;
    logic [6:0] outs [2];

    assign outs[0] = {erase0, expose0, nre1_0, nre2_0, adc0, busy0, done0};
    assign outs[1] = {erase1, expose1, nre1_1, nre2_1, adc1, busy1, done1};

    always #5 Clk = ~Clk;

    camera_seq_fsm dut0 (
        .Clk(Clk), .Reset(rst), .Init(init), .Exp_time(exp_time),
        .Erase(erase0), .Expose(expose0), .NRE_1(nre1_0), .NRE_2(nre2_0),
        .ADC(adc0), .Busy(busy0), .Done(done0)
    );

    camera_seq_fsm #(.ADC_HOLD(3)) dut1 (
        .Clk(Clk), .Reset(rst), .Init(init), .Exp_time(exp_time),
        .Erase(erase1), .Expose(expose1), .NRE_1(nre1_1), .NRE_2(nre2_1),
        .ADC(adc1), .Busy(busy1), .Done(done1)
    );

    localparam logic [6:0] O_IDLE = 7'b1011000;
    localparam logic [6:0] O_EXPO = 7'b0111010;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: a capture is a timeline; n = cycles since Init was taken.
    int hold   [2] = '{1, 3};
    bit m_act  [2] = '{1'b0, 1'b0};
    int m_n    [2] = '{0, 0};
    int m_t    [2] = '{0, 0};

    function automatic int clamp_t(input int e);
        if (e < 2) return 2;
        if (e > 30) return 30;
        return e;
    endfunction

    function automatic logic [6:0] model_out(input int k);
        int p, r, slot;
        logic row2, nre_low, adc, done;
        p = hold[k] + 3;
        if (!m_act[k]) return O_IDLE;
        if (m_n[k] <= m_t[k]) return O_EXPO;
        r       = m_n[k] - m_t[k] - 1;
        row2    = (r >= p);
        slot    = r % p;
        nre_low = (slot <= hold[k] + 1);
        adc     = (slot >= 1) && (slot <= hold[k]);
        done    = (r == 2 * p - 1);
        return {1'b0, 1'b0, !(nre_low && !row2), !(nre_low && row2), adc, 1'b1, done};
    endfunction

    task automatic model_edge(input int k);
        if (rst) begin
            m_act[k] = 1'b0;
        end else if (m_act[k]) begin
            m_n[k] = m_n[k] + 1;
            if (m_n[k] > m_t[k] + 2 * (hold[k] + 3)) m_act[k] = 1'b0;
        end else if (init) begin
            m_act[k] = 1'b1;
            m_n[k]   = 1;
            m_t[k]   = clamp_t(int'(exp_time));
        end
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("model0", outs[0], model_out(0));
        check("model1", outs[1], model_out(1));
    endtask

    typedef struct packed {
        logic       rst;
        logic       init;
        logic [4:0] e;
        logic [6:0] want;
    } vec_t;

    vec_t tbl [20];

    task automatic run_capture(input logic [4:0] e, input bit mid_change,
                               output int x0, output int b0, output int a0, output int d0,
                               output int x1, output int b1, output int a1, output int d1);
        int i;
        x0 = 0; b0 = 0; a0 = 0; d0 = 0;
        x1 = 0; b1 = 0; a1 = 0; d1 = 0;
        exp_time = e;
        init = 1'b1;
        step();
        init = 1'b0;
        for (i = 0; i < 100 && (busy0 || busy1); i++) begin
            if (expose0) x0++;
            if (busy0) b0++;
            if (adc0) a0++;
            if (done0) d0 = b0;
            if (expose1) x1++;
            if (busy1) b1++;
            if (adc1) a1++;
            if (done1) d1 = b1;
            if (mid_change && i == 4) exp_time = 5'd20;
            step();
        end
        check_int("capture_terminates", int'(busy0 || busy1), 0);
    endtask

    initial begin
        int x0, b0, a0, d0, x1, b1, a1, d1;
        int dn0, dn1, er0;

        tbl[0]  = '{1'b1, 1'b0, 5'd0,  O_IDLE};
        tbl[1]  = '{1'b0, 1'b0, 5'd0,  O_IDLE};
        tbl[2]  = '{1'b0, 1'b0, 5'd0,  O_IDLE};
        tbl[3]  = '{1'b0, 1'b0, 5'd0,  O_IDLE};
        tbl[4]  = '{1'b0, 1'b0, 5'd0,  O_IDLE};
        tbl[5]  = '{1'b0, 1'b0, 5'd0,  O_IDLE};
        tbl[6]  = '{1'b0, 1'b1, 5'd0,  O_EXPO};
        tbl[7]  = '{1'b0, 1'b1, 5'd7,  O_EXPO};
        tbl[8]  = '{1'b0, 1'b0, 5'd0,  7'b0001010};
        tbl[9]  = '{1'b0, 1'b1, 5'd0,  7'b0001110};
        tbl[10] = '{1'b0, 1'b0, 5'd0,  7'b0001010};
        tbl[11] = '{1'b0, 1'b0, 5'd0,  7'b0011010};
        tbl[12] = '{1'b0, 1'b0, 5'd0,  7'b0010010};
        tbl[13] = '{1'b0, 1'b0, 5'd0,  7'b0010110};
        tbl[14] = '{1'b0, 1'b0, 5'd0,  7'b0010010};
        tbl[15] = '{1'b0, 1'b1, 5'd0,  7'b0011011};
        tbl[16] = '{1'b0, 1'b1, 5'd0,  O_IDLE};
        tbl[17] = '{1'b0, 1'b1, 5'd31, O_EXPO};
        tbl[18] = '{1'b1, 1'b0, 5'd0,  O_IDLE};
        tbl[19] = '{1'b0, 1'b0, 5'd0,  O_IDLE};

        for (int i = 0; i < 20; i++) begin
            rst      = tbl[i].rst;
            init     = tbl[i].init;
            exp_time = tbl[i].e;
            step();
            check($sformatf("table[%0d]", i), outs[0], tbl[i].want);
        end

        run_capture(5'd10, 1'b0, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("e10_expose", x0, 10);
        check_int("e10_busy", b0, 18);
        check_int("e10_adc", a0, 2);
        check_int("e10_done_at", d0, 18);
        check_int("e10_h3_busy", b1, 22);
        check_int("e10_h3_adc", a1, 6);
        step();

        run_capture(5'd0, 1'b0, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("e0_expose", x0, 2);
        run_capture(5'd1, 1'b0, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("e1_expose", x0, 2);
        run_capture(5'd31, 1'b0, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("e31_expose", x0, 30);
        run_capture(5'd10, 1'b1, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("midchange_expose", x0, 10);
        run_capture(5'd2, 1'b0, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("h3_e2_busy", b1, 14);
        check_int("h3_e2_adc", a1, 6);
        check_int("h3_e2_done_at", d1, 14);

        // Reset in exposure cycle 4.
        exp_time = 5'd10;
        init = 1'b1;
        step();
        init = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_in_expose", outs[0], O_IDLE);
        rst = 1'b0;
        step();
        check("after_rst_expose", outs[0], O_IDLE);

        // Reset in readout cycle 2.
        init = 1'b1;
        step();
        init = 1'b0;
        repeat (12) step();
        check("readout_r2", outs[0], 7'b0001010);
        rst = 1'b1;
        step();
        check("rst_in_readout", outs[0], O_IDLE);
        rst = 1'b0;
        step();
        check("after_rst_readout", outs[0], O_IDLE);
        run_capture(5'd10, 1'b0, x0, b0, a0, d0, x1, b1, a1, d1);
        check_int("post_rst_busy", b0, 18);
        check_int("post_rst_done_at", d0, 18);
        step();

        // Init held high: back-to-back captures separated by one erase cycle.
        dn0 = 0; dn1 = 0; er0 = 0;
        exp_time = 5'd5;
        init = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done0) dn0++;
            if (done1) dn1++;
            if (erase0) er0++;
        end
        init = 1'b0;
        check_int("held_done0", dn0, 4);
        check_int("held_done1", dn1, 3);
        check_int("held_erase0", er0, 4);

        rst = 1'b1;
        step();
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            init     = ($urandom_range(0, 3) == 0);
            exp_time = 5'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
